// File: rtl/mem_if_pkg.sv
// Shared operation encodings and alignment helpers for the memory interface stage.
package mem_if_pkg;

  typedef enum logic [2:0] {
    LB    = 3'b000,
    LH    = 3'b001,
    LW    = 3'b010,
    LNONE = 3'b011,
    LBU   = 3'b100,
    LHU   = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    SB    = 2'b00,
    SH    = 2'b01,
    SW    = 2'b10,
    SNONE = 2'b11
  } store_op_e;

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
  function automatic logic ld_misaligned(input load_op_e op, input logic [1:0] off);
    case (op)
      LH, LHU: return off[0];
      LW:      return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic st_misaligned(input store_op_e op, input logic [1:0] off);
    case (op)
      SH:      return off[0];
      SW:      return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte offset actually used: offending low bits are forced to zero.
  function automatic logic [1:0] ld_align(input load_op_e op, input logic [1:0] off);
    case (op)
      LB, LBU: return off;
      LH, LHU: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] st_align(input store_op_e op, input logic [1:0] off);
    case (op)
      SB:      return off;
      SH:      return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_if_if.sv
// Word-wide req/gnt/rvalid memory bus between mem_if (master) and memory (slave).
interface mem_if_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_if_lane.sv
// Byte-lane steering: store strobe/data placement and load extraction/extension.
module mem_if_lane
  import mem_if_pkg::*;
(
  input  store_op_e   i_st_op,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_strb,
  output logic [31:0] o_st_data,
  input  load_op_e    i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: replicate the datum across lanes, enable only the addressed ones.
  always_comb begin
    o_st_strb = '0;
    o_st_data = i_st_data;
    case (i_st_op)
      SB: begin
        o_st_strb = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      SH: begin
        o_st_strb = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_data = {2{i_st_data[15:0]}};
      end
      SW: begin
        o_st_strb = 4'b1111;
        o_st_data = i_st_data;
      end
      default: begin
        o_st_strb = '0;
        o_st_data = i_st_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    w_byte = '0;
    w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    case (i_ld_off)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    case (i_ld_op)
      LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ld_data = {24'd0, w_byte};
      LH:      o_ld_data = {{16{w_half[15]}}, w_half};
      LHU:     o_ld_data = {16'd0, w_half};
      LW:      o_ld_data = i_ld_word;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_if.sv
// Memory interface stage: posts stores through a one-entry write buffer and
// runs single-word reads on the req/gnt/rvalid bus, returning extended data.
module mem_if
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        misaligned,
  output logic        wr_overrun,
  mem_if_if.master    bus
);

  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } state_e;

  state_e          r_state;

  logic            r_wbuf_full;
  logic [WA_W-1:0] r_wbuf_addr;
  logic [3:0]      r_wbuf_strb;
  logic [31:0]     r_wbuf_data;

  logic            r_rd_pend;
  logic [WA_W-1:0] r_rd_addr;
  logic [1:0]      r_rd_off;
  load_op_e        r_rd_op;

  load_op_e        w_ld_op;
  store_op_e       w_st_op;
  logic            w_rd_new;
  logic            w_st_new;
  logic [1:0]      w_rd_off;
  logic [1:0]      w_st_off;
  logic            w_wr_retire;
  logic            w_st_accept;
  logic            w_st_drop;
  logic            w_wbuf_full_nxt;
  logic [WA_W-1:0] w_wbuf_addr_nxt;
  logic [3:0]      w_wbuf_strb_nxt;
  logic [31:0]     w_wbuf_data_nxt;
  logic [WA_W-1:0] w_rd_addr_nxt;
  logic [3:0]      w_st_strb;
  logic [31:0]     w_st_data;
  logic [31:0]     w_ld_data;
  logic            w_unused_addr;

  assign w_unused_addr = ^mem_addr[31:ADDR_W];

  assign w_ld_op  = load_op_e'(mem_read_op);
  assign w_st_op  = store_op_e'(mem_write_op);
  assign w_rd_new = mem_init && (w_ld_op != LNONE);
  assign w_st_new = (w_st_op != SNONE);
  assign w_rd_off = ld_align(w_ld_op, mem_addr[1:0]);
  assign w_st_off = st_align(w_st_op, mem_addr[1:0]);

  // A store arriving in the same cycle the buffered write is granted takes the
  // freed slot, so the buffer never reports overrun in that case.
  assign w_wr_retire     = (r_state == WR_REQ) && bus.bus_gnt;
  assign w_st_accept     = w_st_new && (!r_wbuf_full || w_wr_retire);
  assign w_st_drop       = w_st_new && !w_st_accept;
  assign w_wbuf_full_nxt = w_st_accept || (r_wbuf_full && !w_wr_retire);
  assign w_wbuf_addr_nxt = w_st_accept ? mem_addr[ADDR_W-1:2] : r_wbuf_addr;
  assign w_wbuf_strb_nxt = w_st_accept ? w_st_strb : r_wbuf_strb;
  assign w_wbuf_data_nxt = w_st_accept ? w_st_data : r_wbuf_data;
  assign w_rd_addr_nxt   = w_rd_new ? mem_addr[ADDR_W-1:2] : r_rd_addr;

  mem_if_lane u_lane (
    .i_st_op   (w_st_op),
    .i_st_off  (w_st_off),
    .i_st_data (mem_wdata),
    .o_st_strb (w_st_strb),
    .o_st_data (w_st_data),
    .i_ld_op   (r_rd_op),
    .i_ld_off  (r_rd_off),
    .i_ld_word (bus.bus_rdata),
    .o_ld_data (w_ld_data)
  );

  // Write buffer: one posted store, retired by the bus grant in WR_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbuf_full <= 1'b0;
      r_wbuf_addr <= '0;
      r_wbuf_strb <= '0;
      r_wbuf_data <= '0;
    end else begin
      r_wbuf_full <= w_wbuf_full_nxt;
      r_wbuf_addr <= w_wbuf_addr_nxt;
      r_wbuf_strb <= w_wbuf_strb_nxt;
      r_wbuf_data <= w_wbuf_data_nxt;
    end
  end

  // Read request latch: the core's address/op are only trusted at mem_init.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_off  <= '0;
      r_rd_op   <= LNONE;
    end else if (w_rd_new) begin
      r_rd_addr <= mem_addr[ADDR_W-1:2];
      r_rd_off  <= w_rd_off;
      r_rd_op   <= w_ld_op;
    end
  end

  // Bus sequencer with registered bus and core-side outputs.
  // IDLE looks at this cycle's captures directly so a read reaches the bus
  // one cycle after mem_init instead of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rd_pend      <= 1'b0;
      mem_ready      <= 1'b0;
      mem_rdata      <= '0;
      misaligned     <= 1'b0;
      wr_overrun     <= 1'b0;
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_wdata  <= '0;
      bus.bus_wstrb  <= '0;
    end else begin
      mem_ready  <= 1'b0;
      misaligned <= (w_st_accept && st_misaligned(w_st_op, mem_addr[1:0])) ||
                    (w_rd_new && ld_misaligned(w_ld_op, mem_addr[1:0]));
      wr_overrun <= w_st_drop;
      case (r_state)
        IDLE: begin
          if (w_wbuf_full_nxt) begin
            r_state       <= WR_REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b1;
            bus.bus_addr  <= w_wbuf_addr_nxt;
            bus.bus_wdata <= w_wbuf_data_nxt;
            bus.bus_wstrb <= w_wbuf_strb_nxt;
          end else if (r_rd_pend || w_rd_new) begin
            r_state       <= RD_REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= w_rd_addr_nxt;
            bus.bus_wdata <= '0;
            bus.bus_wstrb <= '0;
          end
        end
        WR_REQ: begin
          if (bus.bus_gnt) begin
            r_state     <= IDLE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end
        end
        RD_REQ: begin
          if (bus.bus_gnt) begin
            r_state     <= RD_WAIT;
            bus.bus_req <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (bus.bus_rvalid) begin
            r_state   <= RD_DONE;
            mem_rdata <= w_ld_data;
            mem_ready <= 1'b1;
          end
        end
        RD_DONE: begin
          r_state   <= IDLE;
          r_rd_pend <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_rd_new) r_rd_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_if.sv
// Directed self-checking bench for mem_if with a simple gnt/rvalid memory model.
module tb_mem_if;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  logic [31:0] mem_addr;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        misaligned;
  logic        wr_overrun;

  logic        gnt_en   = 1'b1;
  logic        rv_en    = 1'b1;
  logic        stray_rv = 1'b0;
  logic        r_rv     = 1'b0;
  logic [31:0] rd_word  = '0;
  int          wr_cnt   = 0;
  logic [13:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;
  logic [3:0]  wr_strb  = '0;

  int total = 0;
  int bad   = 0;

  mem_if_if #(.ADDR_W(16)) bus ();

  mem_if #(.ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_init     (mem_init),
    .mem_addr     (mem_addr),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .misaligned   (misaligned),
    .wr_overrun   (wr_overrun),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  assign bus.bus_gnt    = bus.bus_req & gnt_en;
  assign bus.bus_rvalid = r_rv | stray_rv;
  assign bus.bus_rdata  = rd_word;

  always @(posedge clk) begin
    r_rv <= (bus.bus_req === 1'b1) && gnt_en && (bus.bus_we === 1'b0) && rv_en;
    if ((bus.bus_req === 1'b1) && gnt_en && (bus.bus_we === 1'b1)) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.bus_addr;
      wr_data <= bus.bus_wdata;
      wr_strb <= bus.bus_wstrb;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    mem_write_op = op;
    mem_addr     = addr;
    mem_wdata    = data;
    tick();
    mem_write_op = SNONE;
  endtask

  // Issues a read at the current cycle and follows it up to 20 cycles.
  task automatic do_read(input logic [2:0] op, input logic [31:0] addr,
                         output int lat, output logic req1, output logic [13:0] req_addr,
                         output int mis, output int rdy);
    mem_read_op = op;
    mem_addr    = addr;
    mem_init    = 1'b1;
    lat = -1; mis = 0; rdy = 0; req1 = 1'b0; req_addr = '0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        mem_init = 1'b0;
        req1     = bus.bus_req;
        req_addr = bus.bus_addr;
      end
      if (misaligned === 1'b1) mis++;
      if (mem_ready === 1'b1) begin
        rdy++;
        if (lat < 0) lat = n;
      end
      if (lat > 0 && n >= lat + 2) break;
    end
    mem_read_op = LNONE;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total++; if (bus.bus_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.bus_req); end
    total++; if (bus.bus_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.bus_we); end
    total++; if ({bus.bus_addr, bus.bus_wdata, bus.bus_wstrb} !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.bus_addr, bus.bus_wdata, bus.bus_wstrb); end
    total++; if ({mem_ready, misaligned, wr_overrun} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {mem_ready, misaligned, wr_overrun}); end
    total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw;
    int lat, mis, rdy; logic req1; logic [13:0] ra;
    rd_word = 32'hDEADBEEF;
    do_read(LW, 32'h0100, lat, req1, ra, mis, rdy);
    total++; if (req1 !== 1'b1) begin bad++; $display("FAIL lw_req_t1 got=%b exp=1", req1); end
    total++; if (ra !== 14'h40) begin bad++; $display("FAIL lw_bus_addr got=%h exp=40", ra); end
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    total++; if (rdy !== 1) begin bad++; $display("FAIL lw_ready_width got=%0d exp=1", rdy); end
    total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", mem_rdata); end
    total++; if (mis !== 0) begin bad++; $display("FAIL lw_misaligned got=%0d exp=0", mis); end
    rd_word = 32'h0;
    tick();
    total++; if (mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata_hold got=%h exp=deadbeef", mem_rdata); end
  endtask

  task automatic test_extend;
    int lat, mis, rdy; logic req1; logic [13:0] ra;
    logic [2:0]  ops [6] = '{LB, LBU, LH, LHU, LB, LH};
    logic [31:0] adr [6] = '{32'h0103, 32'h0103, 32'h0102, 32'h0102, 32'h0101, 32'h0100};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F, 32'h00007F01};
    rd_word = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      do_read(ops[i], adr[i], lat, req1, ra, mis, rdy);
      total++;
      if (mem_rdata !== exp[i] || lat !== 3) begin
        bad++;
        $display("FAIL extend_%0d op=%0d addr=%h got=%h lat=%0d exp=%h lat=3", i, ops[i], adr[i], mem_rdata, lat, exp[i]);
      end
    end
  endtask

  task automatic test_store;
    int w0;
    w0 = wr_cnt;
    do_store(SB, 32'h0201, 32'h000000AB);
    total++; if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1) begin bad++; $display("FAIL sb_req got=%b%b exp=11", bus.bus_req, bus.bus_we); end
    total++; if (bus.bus_wstrb !== 4'b0010) begin bad++; $display("FAIL sb_strb got=%b exp=0010", bus.bus_wstrb); end
    total++; if (bus.bus_wdata[15:8] !== 8'hAB) begin bad++; $display("FAIL sb_lane got=%h exp=ab", bus.bus_wdata[15:8]); end
    total++; if (bus.bus_addr !== 14'h80) begin bad++; $display("FAIL sb_addr got=%h exp=80", bus.bus_addr); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL sb_misaligned got=%b exp=0", misaligned); end
    tick();
    total++; if (bus.bus_req !== 1'b0 || wr_cnt !== w0 + 1) begin bad++; $display("FAIL sb_retire got=req%b cnt%0d exp=req0 cnt%0d", bus.bus_req, wr_cnt, w0 + 1); end
    do_store(SH, 32'h0201, 32'h00001234);
    total++; if (misaligned !== 1'b1 || bus.bus_wstrb !== 4'b0011 || bus.bus_wdata[15:0] !== 16'h1234) begin
      bad++; $display("FAIL sh_misaligned got=mis%b strb%b d%h exp=mis1 strb0011 d1234", misaligned, bus.bus_wstrb, bus.bus_wdata[15:0]);
    end
    tick();
    do_store(SW, 32'h0204, 32'h11223344);
    total++; if (bus.bus_addr !== 14'h81 || bus.bus_wstrb !== 4'b1111 || bus.bus_wdata !== 32'h11223344) begin
      bad++; $display("FAIL sw_bus got=a%h s%b d%h exp=a81 s1111 d11223344", bus.bus_addr, bus.bus_wstrb, bus.bus_wdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int w0, n_rdy; logic seen_rd;
    w0 = wr_cnt; seen_rd = 1'b0; n_rdy = -1;
    gnt_en  = 1'b0;
    rd_word = 32'h0BADF00D;
    do_store(SW, 32'h0300, 32'hCAFEF00D);
    mem_init = 1'b1; mem_read_op = LW; mem_addr = 32'h0304;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) mem_init = 1'b0;
      if (n == 2) begin
        total++; if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1 || bus.bus_addr !== 14'hC0) begin
          bad++; $display("FAIL b2b_wr_held got=r%b w%b a%h exp=r1 w1 aC0", bus.bus_req, bus.bus_we, bus.bus_addr);
        end
      end
      if (n == 3) gnt_en = 1'b1;
      if (bus.bus_req === 1'b1 && bus.bus_we === 1'b0 && !seen_rd) begin
        seen_rd = 1'b1;
        total++; if (wr_cnt !== w0 + 1 || bus.bus_addr !== 14'hC1) begin
          bad++; $display("FAIL b2b_order got=wr%0d a%h exp=wr%0d aC1", wr_cnt, bus.bus_addr, w0 + 1);
        end
      end
      if (mem_ready === 1'b1) begin n_rdy = n; break; end
    end
    mem_read_op = LNONE;
    total++; if (!seen_rd || n_rdy < 0) begin bad++; $display("FAIL b2b_timeout got=rd%b rdy%0d exp=rd1 rdy>0", seen_rd, n_rdy); end
    total++; if (mem_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=0badf00d", mem_rdata); end
    total++; if (wr_data !== 32'hCAFEF00D || wr_strb !== 4'b1111) begin bad++; $display("FAIL b2b_wdata got=%h/%b exp=cafef00d/1111", wr_data, wr_strb); end
    tick(); tick();
  endtask

  task automatic test_misaligned_overrun;
    int lat, mis, rdy, w0; logic req1; logic [13:0] ra;
    rd_word = 32'h11223344;
    do_read(LW, 32'h0102, lat, req1, ra, mis, rdy);
    total++; if (mis !== 1) begin bad++; $display("FAIL lw_mis_pulses got=%0d exp=1", mis); end
    total++; if (ra !== 14'h40 || mem_rdata !== 32'h11223344) begin bad++; $display("FAIL lw_mis_data got=a%h d%h exp=a40 d11223344", ra, mem_rdata); end
    // Second store while the first is stuck waiting for grant.
    w0 = wr_cnt;
    gnt_en = 1'b0;
    do_store(SB, 32'h0400, 32'h00000055);
    do_store(SB, 32'h0404, 32'h00000066);
    total++; if (wr_overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b exp=1", wr_overrun); end
    tick();
    total++; if (wr_overrun !== 1'b0) begin bad++; $display("FAIL overrun_width got=%b exp=0", wr_overrun); end
    gnt_en = 1'b1;
    tick(); tick(); tick();
    total++; if (wr_cnt !== w0 + 1 || wr_addr !== 14'h100 || wr_data[7:0] !== 8'h55 || wr_strb !== 4'b0001) begin
      bad++; $display("FAIL overrun_first got=n%0d a%h d%h s%b exp=n%0d a100 d55 s0001", wr_cnt - w0, wr_addr, wr_data[7:0], wr_strb, 1);
    end
    // Store arriving in the grant cycle of the buffered write is accepted.
    w0 = wr_cnt;
    do_store(SB, 32'h0500, 32'h00000077);
    do_store(SB, 32'h0504, 32'h00000088);
    total++; if (wr_overrun !== 1'b0) begin bad++; $display("FAIL retire_accept_overrun got=%b exp=0", wr_overrun); end
    tick(); tick(); tick();
    total++; if (wr_cnt !== w0 + 2 || wr_addr !== 14'h141 || wr_data[7:0] !== 8'h88) begin
      bad++; $display("FAIL retire_accept_writes got=n%0d a%h d%h exp=n2 a141 d88", wr_cnt - w0, wr_addr, wr_data[7:0]);
    end
  endtask

  task automatic test_reset_mid;
    int lat, mis, rdy, spur; logic req1; logic [13:0] ra;
    spur = 0;
    rv_en = 1'b0;
    rd_word = 32'h76543210;
    mem_init = 1'b1; mem_read_op = LW; mem_addr = 32'h0100;
    tick(); mem_init = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_read_op = LNONE;
    total++; if ({bus.bus_req, bus.bus_we, mem_ready, misaligned, wr_overrun} !== 5'b0 || bus.bus_addr !== '0 || mem_rdata !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%b a%h d%h exp=0", {bus.bus_req, bus.bus_we, mem_ready, misaligned, wr_overrun}, bus.bus_addr, mem_rdata);
    end
    stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (mem_ready === 1'b1 || bus.bus_req === 1'b1) spur++;
      tick();
    end
    total++; if (spur !== 0) begin bad++; $display("FAIL stray_rvalid got=%0d exp=0", spur); end
    rv_en = 1'b1;
    rd_word = 32'h5A5A1234;
    do_read(LW, 32'h0108, lat, req1, ra, mis, rdy);
    total++; if (lat !== 3 || rdy !== 1 || mem_rdata !== 32'h5A5A1234 || ra !== 14'h42) begin
      bad++; $display("FAIL after_reset_lw got=lat%0d rdy%0d d%h a%h exp=lat3 rdy1 d5a5a1234 a42", lat, rdy, mem_rdata, ra);
    end
  endtask

  initial begin
    reset        = 1'b1;
    mem_init     = 1'b0;
    mem_addr     = '0;
    mem_read_op  = LNONE;
    mem_write_op = SNONE;
    mem_wdata    = '0;
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_back_to_back();
    test_misaligned_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_if.md
Name: mem_if

Overview:
Memory interface stage directly downstream of the core control FSM. It turns the core's mem_init / read-op / write-op strobes into single-word transactions on a word-wide, req/gnt/rvalid memory bus, and returns lane-extracted, sign/zero-extended load data to the core with a one-cycle mem_ready pulse. Stores are posted into a one-entry write buffer, so the core's single-cycle MEM_WRITE state never stalls; a subsequent read waits until the buffered write has been granted.

Parameters:
ADDR_W, 16, byte-address width used by the block; bus_addr carries bits [ADDR_W-1:2].

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_init  in  1  one-cycle pulse; starts a read when mem_read_op != LNONE
mem_addr  in  32  byte address (already muxed by core); bits [ADDR_W-1:0] used
mem_read_op  in  3  LB/LH/LW/LBU/LHU/LNONE; held by core until mem_ready
mem_write_op  in  2  SB/SH/SW/SNONE; non-SNONE for exactly one cycle per store
mem_wdata  in  32  store data (rs2), valid with mem_write_op
mem_ready  out  1  one-cycle pulse: read data valid
mem_rdata  out  32  extended load data; held until next read completes
misaligned  out  1  one-cycle pulse when a misaligned access is accepted
wr_overrun  out  1  one-cycle pulse when a store is dropped (buffer full)
bus_req  out  1  request; held until bus_gnt
bus_we  out  1  1 = write, valid with bus_req
bus_addr  out  ADDR_W-2  word address
bus_wdata  out  32  lane-shifted store data
bus_wstrb  out  4  byte enables
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid (>=1 cycle after gnt of a read)
bus_rdata  in  32  read word

Behaviour:
- Reset (synchronous): state IDLE, write buffer empty, pending-read flag clear; mem_ready, misaligned, wr_overrun, bus_req, bus_we = 0; bus_addr, bus_wdata, bus_wstrb, mem_rdata = 0. Reset mid-transaction abandons it; bus_rvalid arriving while IDLE is ignored.
- All outputs registered.
- Store capture: mem_write_op != SNONE → latch word address, strobe (SB: 1<<addr[1:0]; SH: 4'b0011<<{addr[1],1'b0}; SW: 4'b1111) and data replicated/shifted to lane. Buffer already full → store dropped, wr_overrun pulses.
- Read capture: mem_init with op != LNONE → latch word address, addr[1:0], op; pending-read set. mem_init with LNONE → ignored.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 → misaligned pulses the cycle after capture; access proceeds with offending low bits forced to 0 (lane 0 / half 0).
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.
  - IDLE: buffer full → WR_REQ; else pending-read → RD_REQ. Write has priority.
  - WR_REQ: bus_req=1, bus_we=1; on bus_gnt → buffer empty, IDLE.
  - RD_REQ: bus_req=1, bus_we=0, bus_wstrb=0; on bus_gnt → RD_WAIT.
  - RD_WAIT: on bus_rvalid → capture extracted data into mem_rdata, → RD_DONE.
  - RD_DONE: mem_ready=1 for this cycle only, pending-read cleared, → IDLE.
- Simultaneous store capture and bus_gnt of the buffered write: old entry retires, new one is accepted (no overrun).
- Load extraction: LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes the word.
- Latency: zero-wait bus (gnt same cycle as req, rvalid next): mem_init at T → bus_req T+1 → rvalid T+2 → mem_ready T+3. A pending store adds >=1 cycle.
- Constraint: the core must not change mem_addr/mem_read_op between mem_init and mem_ready; the block uses only its latched copies.

Decomposition:
- Shared include (defs.inc): LNONE=3'b011, LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101; SB=2'b00, SH=2'b01, SW=2'b10, SNONE=2'b11; FSM state encodings local to mem_if.
- Sub-module mem_lane (combinational): store strobe/data shifting and load extraction/extension, shared by both paths and unit-testable in isolation.

Test Plan:
- LW addr 0x0100, bus word 0xDEADBEEF, zero-wait → bus_addr=0x40, mem_rdata=0xDEADBEEF, mem_ready exactly at T+3, one cycle wide.
- LB/LBU addr 0x0103, word 0x80FF7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080; LH addr 0x0102 gives 0xFFFF80FF.
- SB addr 0x0201, data 0x000000AB → bus_we=1, bus_wstrb=4'b0010, bus_wdata[15:8]=0xAB; the core is never stalled.
- SW addr 0x0300 then mem_init LW addr 0x0304 next cycle, gnt delayed 3 cycles → write granted first, read req only after, mem_ready after rvalid.
- LW addr 0x0102 → misaligned pulses once, bus_addr=0x40; second store while buffer full (gnt held low) → wr_overrun pulses, first store is still written.
- Reset asserted in RD_WAIT, then stray rvalid → no mem_ready, all outputs at reset values, next LW completes normally.
